ppu_slot_scheduler: RTL and testbench

Per-tile entity scheduler that feeds the Sprite ROM in the picture processing unit.
- On each tile-ahead strobe, scans the 15 entity/dragon slots in priority order and selects the first slot that covers the tile.
- Issues one row-fetch request to the shared Sprite ROM port over a valid/ready handshake, or reports a blank tile.
- Replaces the free-running entity counter with a bounded, deterministic scan and an overrun flag.

---
 rtl/ppu_slot_scheduler.sv | 160 ++++++++++++++++
 tb/tb_ppu_slot_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_slot_scheduler.sv
// Per-tile sprite slot scheduler: priority scan of the entity slots, then one Sprite ROM row request.
// Build option ARRAY_SLOTS_EN: a slot's [3:0] length field extends its horizontal coverage.
`timescale 1ns/1ps
module ppu_slot_scheduler #(
  parameter int NUM_SLOTS = 15,
  parameter int SLOT_W    = 20
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_SLOTS*SLOT_W-1:0] slots,
  input  logic                        tile_start,
  input  logic [4:0]                  tile_x,
  input  logic [4:0]                  tile_y,
  input  logic [2:0]                  line_index,
  output logic                        req_valid,
  input  logic                        req_ready,
  output logic [3:0]                  req_id,
  output logic [1:0]                  req_orient,
  output logic [2:0]                  req_line,
  output logic [3:0]                  req_slot,
  output logic                        result_valid,
  output logic                        result_hit,
  output logic                        busy,
  output logic                        overrun
);

  typedef enum logic [1:0] {IDLE, SCAN, ISSUE, DONE} state_t;

  localparam logic [3:0] EMPTY_ID = 4'hF;
  localparam logic [3:0] LAST_IDX = 4'(NUM_SLOTS - 1);

  state_t     state;
  logic [3:0] idx;
  logic [4:0] cur_x, cur_y;
  logic [2:0] cur_line;
  logic       pending;
  logic [4:0] pend_x, pend_y;
  logic [2:0] pend_line;

  // Fields of the slot under examination, read live from the slot bus.
  logic [3:0] s_id;
  logic [1:0] s_orient;
  logic [4:0] s_x, s_y;
  logic       x_match, slot_hit;

  assign s_id     = slots[int'(idx)*SLOT_W + 16 +: 4];
  assign s_orient = slots[int'(idx)*SLOT_W + 14 +: 2];
  assign s_x      = slots[int'(idx)*SLOT_W + 9  +: 5];
  assign s_y      = slots[int'(idx)*SLOT_W + 4  +: 5];

`ifdef ARRAY_SLOTS_EN
  logic [3:0] s_len;
  logic [5:0] x_end;
  assign s_len   = slots[int'(idx)*SLOT_W +: 4];
  // Six-bit end column so a run reaching past column 31 never wraps to the left edge.
  assign x_end   = {1'b0, s_x} + {2'b00, s_len};
  assign x_match = (cur_x >= s_x) && ({1'b0, cur_x} <= x_end);
`else
  assign x_match = (s_x == cur_x);
`endif

  assign slot_hit = (s_id != EMPTY_ID) && (s_y == cur_y) && x_match;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      idx          <= '0;
      cur_x        <= '0;
      cur_y        <= '0;
      cur_line     <= '0;
      pending      <= 1'b0;
      pend_x       <= '0;
      pend_y       <= '0;
      pend_line    <= '0;
      req_valid    <= 1'b0;
      req_id       <= '0;
      req_orient   <= '0;
      req_line     <= '0;
      req_slot     <= '0;
      result_valid <= 1'b0;
      result_hit   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low here so each branch only states when they fire;
      // a later non-blocking assignment in the same pass wins.
      result_valid <= 1'b0;
      result_hit   <= 1'b0;
      overrun      <= 1'b0;
      case (state)
        IDLE: begin
          if (tile_start) begin
            cur_x    <= tile_x;
            cur_y    <= tile_y;
            cur_line <= line_index;
            idx      <= '0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (tile_start) begin
            cur_x    <= tile_x;
            cur_y    <= tile_y;
            cur_line <= line_index;
            idx      <= '0;
            overrun  <= 1'b1;
          end else if (slot_hit) begin
            req_id     <= s_id;
            req_orient <= s_orient;
            req_line   <= cur_line;
            req_slot   <= idx;
            req_valid  <= 1'b1;
            state      <= ISSUE;
          end else if (idx == LAST_IDX) begin
            result_valid <= 1'b1;
            state        <= DONE;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        ISSUE: begin
          // An in-flight handshake is never broken; a new tile waits in the pending slot.
          if (tile_start) begin
            pending   <= 1'b1;
            pend_x    <= tile_x;
            pend_y    <= tile_y;
            pend_line <= line_index;
            overrun   <= 1'b1;
          end
          if (req_ready) begin
            req_valid    <= 1'b0;
            result_valid <= 1'b1;
            result_hit   <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          pending <= 1'b0;
          idx     <= '0;
          if (tile_start) begin
            cur_x    <= tile_x;
            cur_y    <= tile_y;
            cur_line <= line_index;
            overrun  <= 1'b1;
            state    <= SCAN;
          end else if (pending) begin
            cur_x    <= pend_x;
            cur_y    <= pend_y;
            cur_line <= pend_line;
            state    <= SCAN;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ppu_slot_scheduler.sv
// Bench for ppu_slot_scheduler: vector table, cycle traces for stall/abort/reset, random slots vs a priority model.
`timescale 1ns/1ps
module tb_ppu_slot_scheduler;

  localparam int NUM_SLOTS = 15;
  localparam int SLOT_W    = 20;
  localparam int TRACE_N   = 40;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [NUM_SLOTS*SLOT_W-1:0] slots;
  logic                        tile_start;
  logic [4:0]                  tile_x, tile_y;
  logic [2:0]                  line_index;
  logic                        req_valid, req_ready;
  logic [3:0]                  req_id, req_slot;
  logic [1:0]                  req_orient;
  logic [2:0]                  req_line;
  logic                        result_valid, result_hit, busy, overrun;

  ppu_slot_scheduler #(.NUM_SLOTS(NUM_SLOTS), .SLOT_W(SLOT_W)) dut (
    .clk(clk), .reset(reset), .slots(slots),
    .tile_start(tile_start), .tile_x(tile_x), .tile_y(tile_y), .line_index(line_index),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id), .req_orient(req_orient),
    .req_line(req_line), .req_slot(req_slot), .result_valid(result_valid),
    .result_hit(result_hit), .busy(busy), .overrun(overrun)
  );

  always #20 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic set_slot(input int k, input int id, input int orient, input int x, input int y, input int len);
    slots[k*SLOT_W +: SLOT_W] = {4'(id), 2'(orient), 5'(x), 5'(y), 4'(len)};
  endtask

  task automatic base_config();
    slots = '1;
    set_slot(0, 1, 2, 10, 10, 0);
    set_slot(2, 5, 1, 3, 4, 0);
    set_slot(6, 15, 0, 20, 20, 0);
    set_slot(9, 7, 3, 3, 4, 0);
    set_slot(14, 14, 2, 31, 31, 0);
  endtask

  // Reference rule: first non-empty slot whose row matches and whose column span covers the tile.
  function automatic bit covers(input int k, input int tx, input int ty);
    logic [SLOT_W-1:0] s;
    s = slots[k*SLOT_W +: SLOT_W];
    if (s[19:16] == 4'hF) return 1'b0;
    if (int'(s[8:4]) != ty) return 1'b0;
`ifdef ARRAY_SLOTS_EN
    return (tx >= int'(s[13:9])) && (tx <= int'(s[13:9]) + int'(s[3:0]));
`else
    return int'(s[13:9]) == tx;
`endif
  endfunction

  function automatic int first_cover(input int tx, input int ty);
    for (int k = 0; k < NUM_SLOTS; k++)
      if (covers(k, tx, ty)) return k;
    return -1;
  endfunction

  // Runs one tile from IDLE; cycle 0 is the tile_start cycle.
  task automatic run_tile(input int tx, input int ty, input int ln, input bit rnd,
                          output int o_hit, output int o_slot, output int o_id, output int o_or,
                          output int o_line, output int o_req, output int o_res, output int o_hs);
    bit pv, pr;
    int p_id, p_or, p_ln, p_sl;
    o_hit = -1; o_slot = -1; o_id = -1; o_or = -1; o_line = -1; o_req = -1; o_res = -1; o_hs = -1;
    pv = 0; pr = 0; p_id = 0; p_or = 0; p_ln = 0; p_sl = 0;
    @(posedge clk); #1;
    tile_start = 1'b1; tile_x = 5'(tx); tile_y = 5'(ty); line_index = 3'(ln);
    req_ready = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (req_valid) begin
        if (o_req < 0) begin
          o_req = c; o_slot = req_slot; o_id = req_id; o_or = req_orient; o_line = req_line;
        end
        if (pv && !pr) begin
          check("stall_hold_id", req_id, p_id);
          check("stall_hold_orient", req_orient, p_or);
          check("stall_hold_line", req_line, p_ln);
          check("stall_hold_slot", req_slot, p_sl);
        end
        if (req_ready && o_hs < 0) o_hs = c;
      end
      pv = req_valid; pr = req_ready;
      p_id = req_id; p_or = req_orient; p_ln = req_line; p_sl = req_slot;
      if (result_valid) begin
        o_res = c; o_hit = result_hit;
        break;
      end
      @(posedge clk); #1;
      tile_start = 1'b0;
      req_ready = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
    end
    tile_start = 1'b0;
    if (o_res < 0) check("tile_timeout", 0, 1);
  endtask

  typedef struct {
    int tx, ty, ln;
    int hit, slot, id, orient, res;
  } vec_t;

  vec_t vecs[$];

  task automatic run_vectors(input string tag);
    int g_hit, g_slot, g_id, g_or, g_line, g_req, g_res, g_hs;
    foreach (vecs[i]) begin
      run_tile(vecs[i].tx, vecs[i].ty, vecs[i].ln, 1'b0, g_hit, g_slot, g_id, g_or, g_line, g_req, g_res, g_hs);
      check($sformatf("%s[%0d]_hit", tag, i), g_hit, vecs[i].hit);
      check($sformatf("%s[%0d]_result_cycle", tag, i), g_res, vecs[i].res);
      if (vecs[i].hit != 0) begin
        check($sformatf("%s[%0d]_req_cycle", tag, i), g_req, vecs[i].res - 1);
        check($sformatf("%s[%0d]_slot", tag, i), g_slot, vecs[i].slot);
        check($sformatf("%s[%0d]_id", tag, i), g_id, vecs[i].id);
        check($sformatf("%s[%0d]_orient", tag, i), g_or, vecs[i].orient);
        check($sformatf("%s[%0d]_line", tag, i), g_line, vecs[i].ln);
      end else begin
        check($sformatf("%s[%0d]_no_req", tag, i), g_req, -1);
      end
    end
    vecs.delete();
  endtask

  // Per-cycle stimulus schedule and sampled trace for the multi-cycle corner cases.
  int st_start[TRACE_N], st_x[TRACE_N], st_y[TRACE_N], st_ln[TRACE_N], st_rdy[TRACE_N], st_rst[TRACE_N];
  int tr_rv[TRACE_N], tr_ov[TRACE_N], tr_res[TRACE_N], tr_hit[TRACE_N], tr_busy[TRACE_N];
  int tr_id[TRACE_N], tr_or[TRACE_N], tr_ln[TRACE_N], tr_sl[TRACE_N];

  task automatic clear_sched();
    for (int c = 0; c < TRACE_N; c++) begin
      st_start[c] = 0; st_x[c] = 0; st_y[c] = 0; st_ln[c] = 0; st_rdy[c] = 1; st_rst[c] = 0;
    end
  endtask

  task automatic run_trace();
    for (int c = 0; c < TRACE_N; c++) begin
      @(posedge clk); #1;
      tile_start = (st_start[c] != 0);
      tile_x = 5'(st_x[c]); tile_y = 5'(st_y[c]); line_index = 3'(st_ln[c]);
      req_ready = (st_rdy[c] != 0);
      reset = (st_rst[c] != 0) ? 1'b0 : 1'b1;
      @(negedge clk);
      tr_rv[c] = req_valid; tr_ov[c] = overrun; tr_res[c] = result_valid; tr_hit[c] = result_hit;
      tr_busy[c] = busy; tr_id[c] = req_id; tr_or[c] = req_orient; tr_ln[c] = req_line; tr_sl[c] = req_slot;
    end
    tile_start = 1'b0;
    reset = 1'b1;
  endtask

  function automatic int count_of(input int which);
    int n = 0;
    for (int c = 0; c < TRACE_N; c++)
      n += (which == 0) ? tr_ov[c] : tr_res[c];
    return n;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g_hit, g_slot, g_id, g_or, g_line, g_req, g_res, g_hs;
    int tx, ty, ln, k;
    int xpool[8] = '{0, 1, 2, 3, 28, 29, 30, 31};

    reset = 1'b0; tile_start = 1'b0; tile_x = '0; tile_y = '0; line_index = '0;
    req_ready = 1'b0; slots = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_valid", req_valid, 0);
    check("reset_result_valid", result_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_overrun", overrun, 0);
    check("reset_req_fields", {req_id, req_orient, req_line, req_slot}, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // All slots empty: blank tile reported at cycle 16.
    run_tile(3, 4, 0, 1'b0, g_hit, g_slot, g_id, g_or, g_line, g_req, g_res, g_hs);
    check("empty_no_req", g_req, -1);
    check("empty_result_cycle", g_res, 16);
    check("empty_result_hit", g_hit, 0);

    base_config();
    vecs.push_back('{tx: 3,  ty: 4,  ln: 3, hit: 1, slot: 2,  id: 5,  orient: 1, res: 5});
    vecs.push_back('{tx: 10, ty: 10, ln: 7, hit: 1, slot: 0,  id: 1,  orient: 2, res: 3});
    vecs.push_back('{tx: 31, ty: 31, ln: 1, hit: 1, slot: 14, id: 14, orient: 2, res: 17});
    vecs.push_back('{tx: 20, ty: 20, ln: 0, hit: 0, slot: 0,  id: 0,  orient: 0, res: 16});
    vecs.push_back('{tx: 3,  ty: 5,  ln: 0, hit: 0, slot: 0,  id: 0,  orient: 0, res: 16});
    vecs.push_back('{tx: 0,  ty: 0,  ln: 2, hit: 0, slot: 0,  id: 0,  orient: 0, res: 16});
    run_vectors("base");

    // Column-span edge cases for a slot starting at column 30 with length 4.
    slots = '1;
    set_slot(5, 3, 0, 30, 7, 4);
`ifdef ARRAY_SLOTS_EN
    vecs.push_back('{tx: 31, ty: 7, ln: 4, hit: 1, slot: 5, id: 3, orient: 0, res: 8});
    vecs.push_back('{tx: 29, ty: 7, ln: 4, hit: 0, slot: 0, id: 0, orient: 0, res: 16});
`else
    vecs.push_back('{tx: 31, ty: 7, ln: 4, hit: 0, slot: 0, id: 0, orient: 0, res: 16});
`endif
    vecs.push_back('{tx: 30, ty: 7, ln: 6, hit: 1, slot: 5, id: 3, orient: 0, res: 8});
    vecs.push_back('{tx: 2,  ty: 7, ln: 0, hit: 0, slot: 0, id: 0, orient: 0, res: 16});
    run_vectors("span");

    // Stall on a slot-0 hit, with a second tile arriving mid-stall.
    base_config();
    clear_sched();
    st_start[0] = 1; st_x[0] = 10; st_y[0] = 10; st_ln[0] = 5;
    st_start[4] = 1; st_x[4] = 3;  st_y[4] = 4;  st_ln[4] = 2;
    for (int c = 0; c < 8; c++) st_rdy[c] = 0;
    run_trace();
    check("stall_busy_c1", tr_busy[1], 1);
    check("stall_req_valid_c1", tr_rv[1], 0);
    for (int c = 2; c < 8; c++) begin
      check($sformatf("stall_c%0d_valid", c), tr_rv[c], 1);
      check($sformatf("stall_c%0d_fields", c), {tr_id[c], tr_or[c], tr_ln[c], tr_sl[c]}, {1, 2, 5, 0});
    end
    check("stall_handshake_c8", tr_rv[8], 1);
    check("stall_drop_c9", tr_rv[9], 0);
    check("stall_overrun_c5", tr_ov[5], 1);
    check("stall_overrun_count", count_of(0), 1);
    check("stall_result1_c9", tr_res[9] + tr_hit[9], 2);
    check("stall_second_req_c13", tr_rv[13], 1);
    check("stall_second_fields", tr_sl[13] * 16 + tr_ln[13], 2 * 16 + 2);
    check("stall_result2_c14", tr_res[14] + tr_hit[14], 2);
    check("stall_result_count", count_of(1), 2);

    // Restart during SCAN: the aborted tile produces no result.
    clear_sched();
    st_start[0] = 1; st_x[0] = 0; st_y[0] = 0; st_ln[0] = 1;
    st_start[5] = 1; st_x[5] = 3; st_y[5] = 4; st_ln[5] = 6;
    run_trace();
    check("abort_overrun_c6", tr_ov[6], 1);
    check("abort_overrun_count", count_of(0), 1);
    check("abort_req_c9", tr_rv[9], 1);
    check("abort_req_fields", {tr_id[9], tr_sl[9], tr_ln[9]}, {5, 2, 6});
    check("abort_result_c10", tr_res[10] + tr_hit[10], 2);
    check("abort_result_count", count_of(1), 1);

    // Reset while a request is stalled, then a clean tile.
    clear_sched();
    st_start[0] = 1; st_x[0] = 10; st_y[0] = 10; st_ln[0] = 3;
    for (int c = 0; c < 4; c++) st_rdy[c] = 0;
    st_rst[3] = 1;
    st_start[6] = 1; st_x[6] = 3; st_y[6] = 4; st_ln[6] = 1;
    run_trace();
    check("rst_req_before", tr_rv[3], 1);
    check("rst_req_valid_after", tr_rv[4], 0);
    check("rst_busy_after", tr_busy[4], 0);
    check("rst_fields_after", {tr_id[4], tr_sl[4]}, 0);
    check("rst_then_req_c10", tr_rv[10] * 16 + tr_sl[10], 16 + 2);
    check("rst_then_result_c11", tr_res[11] + tr_hit[11], 2);
    check("rst_result_count", count_of(1), 1);

    // Random slot tables and ROM back-pressure against the priority rule.
    for (int it = 0; it < 40; it++) begin
      for (int s = 0; s < NUM_SLOTS; s++)
        set_slot(s, ($urandom_range(0, 1) != 0) ? 15 : int'($urandom_range(0, 14)),
                 int'($urandom_range(0, 3)), xpool[$urandom_range(0, 7)],
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
      tx = xpool[$urandom_range(0, 7)];
      ty = int'($urandom_range(0, 1));
      ln = int'($urandom_range(0, 7));
      k = first_cover(tx, ty);
      run_tile(tx, ty, ln, 1'b1, g_hit, g_slot, g_id, g_or, g_line, g_req, g_res, g_hs);
      check($sformatf("rand%0d_hit", it), g_hit, (k >= 0) ? 1 : 0);
      if (k >= 0) begin
        check($sformatf("rand%0d_slot", it), g_slot, k);
        check($sformatf("rand%0d_id", it), g_id, int'(slots[k*SLOT_W + 16 +: 4]));
        check($sformatf("rand%0d_orient", it), g_or, int'(slots[k*SLOT_W + 14 +: 2]));
        check($sformatf("rand%0d_line", it), g_line, ln);
        check($sformatf("rand%0d_req_cycle", it), g_req, k + 2);
        check($sformatf("rand%0d_result_after_hs", it), g_res, g_hs + 1);
      end else begin
        check($sformatf("rand%0d_no_req", it), g_req, -1);
        check($sformatf("rand%0d_result_cycle", it), g_res, 16);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
